// File: rtl/cache_fill_wb_ctrl.sv
// Miss handler for a write-back cache. It writes back a dirty victim block, fills the
// missing block beat by beat, and then writes the tag.
module cache_fill_wb_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int OFFSET_W   = 4,
  parameter int WORD_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_detected,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                victim_dirty,
  input  logic [ADDR_W-1:0]   victim_addr,
  input  logic                mem_ready,
  input  logic                memory_data_valid,
  output logic                fsm_busy,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                read_data_array,
  output logic                write_data_array,
  output logic [OFFSET_W-1:0] cache_word_offset,
  output logic                write_tag_array,
  output logic [ADDR_W-1:0]   base_addr,
  output logic [1:0]          state_dbg
);

  localparam int BLOCK_BYTES = 1 << OFFSET_W;
  localparam logic [OFFSET_W-1:0] STEP = OFFSET_W'(WORD_BYTES);
  localparam logic [OFFSET_W-1:0] LAST = OFFSET_W'(BLOCK_BYTES - WORD_BYTES);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, TAG} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, victim_q;
  logic [OFFSET_W-1:0] wb_off_q, rd_off_q, wr_off_q;
  logic                rd_done_q;

  // Handshake: a request (mem_read or mem_write) is accepted on a rising edge where
  // mem_ready is also 1. The request stays asserted with a stable address until it is accepted.
  // Read beats return in order, one per cycle at most, flagged by memory_data_valid.
  always_comb begin
    state_d           = state_q;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_addr          = '0;
    read_data_array   = 1'b0;
    write_data_array  = 1'b0;
    cache_word_offset = '0;
    write_tag_array   = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) state_d = victim_dirty ? WB : FILL;
      end
      WB: begin
        mem_write         = 1'b1;
        read_data_array   = 1'b1;
        mem_addr          = victim_q + ADDR_W'(wb_off_q);
        cache_word_offset = wb_off_q;
        if (mem_ready && wb_off_q == LAST) state_d = FILL;
      end
      FILL: begin
        mem_read          = !rd_done_q;
        if (!rd_done_q) mem_addr = base_q + ADDR_W'(rd_off_q);
        write_data_array  = memory_data_valid;
        cache_word_offset = wr_off_q;
        if (memory_data_valid && wr_off_q == LAST) state_d = TAG;
      end
      TAG: begin
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      victim_q  <= '0;
      wb_off_q  <= '0;
      rd_off_q  <= '0;
      wr_off_q  <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q    <= miss_addr & BASE_MASK;
            victim_q  <= victim_addr & BASE_MASK;
            wb_off_q  <= '0;
            rd_off_q  <= '0;
            wr_off_q  <= '0;
            rd_done_q <= 1'b0;
          end
        end
        WB: begin
          if (mem_ready) wb_off_q <= (wb_off_q == LAST) ? '0 : wb_off_q + STEP;
        end
        FILL: begin
          // rd_off stops at the last beat; rd_done then drops the read request.
          if (mem_read && mem_ready) begin
            if (rd_off_q == LAST) rd_done_q <= 1'b1;
            else                  rd_off_q  <= rd_off_q + STEP;
          end
          if (memory_data_valid) begin
            if (wr_off_q == LAST) begin
              wr_off_q  <= '0;
              rd_off_q  <= '0;
              rd_done_q <= 1'b0;
            end else begin
              wr_off_q <= wr_off_q + STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_busy  = (state_q != IDLE);
  assign base_addr = base_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cache_fill_wb_ctrl.sv
// Bench for cache_fill_wb_ctrl. A transaction model lists the expected writeback, fill-request
// and array-write sequences per miss. A memory responder returns the read beats in order.
module tb_cache_fill_wb_ctrl;
  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, miss_detected, victim_dirty, mem_ready, memory_data_valid;
  logic [ADDR_W-1:0] miss_addr, victim_addr;

  logic a_busy, a_rd, a_wr, a_rda, a_wda, a_tag;
  logic [ADDR_W-1:0] a_addr, a_base;
  logic [3:0] a_off;
  logic [1:0] a_st;
  logic b_busy, b_rd, b_wr, b_rda, b_wda, b_tag;
  logic [ADDR_W-1:0] b_addr, b_base;
  logic [2:0] b_off;
  logic [1:0] b_st;

  cache_fill_wb_ctrl #(.ADDR_W(16), .OFFSET_W(4), .WORD_BYTES(2)) dut_a (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .mem_ready(mem_ready),
    .memory_data_valid(memory_data_valid), .fsm_busy(a_busy), .mem_read(a_rd),
    .mem_write(a_wr), .mem_addr(a_addr), .read_data_array(a_rda),
    .write_data_array(a_wda), .cache_word_offset(a_off), .write_tag_array(a_tag),
    .base_addr(a_base), .state_dbg(a_st));

  cache_fill_wb_ctrl #(.ADDR_W(16), .OFFSET_W(3), .WORD_BYTES(1)) dut_b (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .mem_ready(mem_ready),
    .memory_data_valid(memory_data_valid), .fsm_busy(b_busy), .mem_read(b_rd),
    .mem_write(b_wr), .mem_addr(b_addr), .read_data_array(b_rda),
    .write_data_array(b_wda), .cache_word_offset(b_off), .write_tag_array(b_tag),
    .base_addr(b_base), .state_dbg(b_st));

  // sel picks which instance is under observation; both see the same inputs.
  logic sel;
  logic o_busy, o_rd, o_wr, o_rda, o_wda, o_tag;
  logic [ADDR_W-1:0] o_addr, o_base;
  logic [3:0] o_off;
  always_comb begin
    o_busy = sel ? b_busy : a_busy;
    o_rd   = sel ? b_rd   : a_rd;
    o_wr   = sel ? b_wr   : a_wr;
    o_rda  = sel ? b_rda  : a_rda;
    o_wda  = sel ? b_wda  : a_wda;
    o_tag  = sel ? b_tag  : a_tag;
    o_addr = sel ? b_addr : a_addr;
    o_base = sel ? b_base : a_base;
    o_off  = sel ? {1'b0, b_off} : a_off;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [ADDR_W-1:0] exp_base);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_req"}, {o_rd, o_wr, o_rda, o_wda, o_tag}, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_off"}, o_off, 0);
    chk({tag, "_base"}, o_base, exp_base);
  endtask

  task automatic pulse_reset();
    @(negedge clk); cyc++;
    rst = 1'b1; miss_detected = 1'b0; mem_ready = 1'b0; memory_data_valid = 1'b0;
    @(negedge clk); cyc++;
    rst = 1'b0;
    #1 chk_quiet("reset", 16'h0);
  endtask

  // ---------------- driver + reference model ----------------
  // rmode: 0 random ready, 1 always ready, 2 ready every other cycle.
  // inject_at: loop cycle at which a stray miss is pulsed (-1 none).
  // rst_after: number of fill beats after which rst is asserted (-1 none).
  task automatic run_miss(input logic [ADDR_W-1:0] addr, input logic dirty,
                          input logic [ADDR_W-1:0] vaddr, input int rmode, input int lat,
                          input int inject_at, input int rst_after);
    int ow, wbytes, words, fills, tags, last_t;
    bit done;
    logic [ADDR_W-1:0] mask, base, vbase;
    logic [ADDR_W-1:0] exp_wr_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    int pend_q[$];
    ow = sel ? 3 : 4;
    wbytes = sel ? 1 : 2;
    words = (1 << ow) / wbytes;
    mask  = ~16'((1 << ow) - 1);
    base  = addr & mask;
    vbase = vaddr & mask;
    for (int k = 0; k < words; k++) begin
      if (dirty) exp_wr_q.push_back(vbase + 16'(k * wbytes));
      exp_rd_q.push_back(base + 16'(k * wbytes));
      exp_q.push_back(16'(k * wbytes));
    end
    fills = 0; tags = 0; last_t = 0; done = 0;

    @(negedge clk); cyc++;
    miss_detected = 1'b1; miss_addr = addr; victim_dirty = dirty; victim_addr = vaddr;
    mem_ready = 1'b0; memory_data_valid = 1'b0;
    #1 chk("busy_before_accept", o_busy, 0);

    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk); cyc++;
      miss_detected = 1'b0;
      if (c == inject_at) begin
        miss_detected = 1'b1;
        miss_addr     = 16'($urandom);
        victim_addr   = 16'($urandom);
        victim_dirty  = 1'($urandom_range(0, 1));
      end
      if (rst_after >= 0 && fills == rst_after) begin
        rst = 1'b1; mem_ready = 1'b0; memory_data_valid = 1'b0;
        @(negedge clk); cyc++;
        rst = 1'b0;
        #1 chk_quiet("mid_reset", 16'h0);
        return;
      end
      case (rmode)
        1:       mem_ready = 1'b1;
        2:       mem_ready = (cyc % 2) == 1;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      memory_data_valid = (pend_q.size() > 0) && (pend_q[0] <= cyc);
      #1;
      if (!o_busy) begin
        done = 1;
        chk("tag_once", tags, 1);
        chk("wb_drained", exp_wr_q.size(), 0);
        chk("rd_drained", exp_rd_q.size(), 0);
        chk("fill_drained", exp_q.size(), 0);
        chk_quiet("idle", base);
      end else begin
        chk("base_addr", o_base, base);
        chk("rw_excl", o_rd & o_wr, 0);
        if (o_wr) begin
          if (exp_wr_q.size() == 0) chk("wb_extra", o_wr, 0);
          else begin
            chk("wb_addr", o_addr, exp_wr_q[0]);
            chk("wb_off", o_off, exp_wr_q[0] - vbase);
            chk("wb_rda", o_rda, 1);
            if (mem_ready) void'(exp_wr_q.pop_front());
          end
        end
        if (o_rd) begin
          if (exp_wr_q.size() > 0) chk("rd_before_wb", o_rd, 0);
          else if (exp_rd_q.size() == 0) chk("rd_extra", o_rd, 0);
          else begin
            chk("rd_addr", o_addr, exp_rd_q[0]);
            if (mem_ready) begin
              void'(exp_rd_q.pop_front());
              last_t = (cyc + lat > last_t + 1) ? cyc + lat : last_t + 1;
              pend_q.push_back(last_t);
            end
          end
        end
        if (memory_data_valid) begin
          void'(pend_q.pop_front());
          if (exp_q.size() == 0) chk("fill_extra", o_wda, 0);
          else begin
            chk("fill_we", o_wda, 1);
            chk("fill_off", o_off, exp_q.pop_front());
            fills++;
          end
        end else begin
          chk("no_fill_we", o_wda, 0);
        end
        if (o_tag) begin
          tags++;
          chk("tag_after_fill", exp_q.size(), 0);
          chk("tag_no_req", o_rd | o_wr | o_rda | o_wda, 0);
        end
      end
    end
    if (!done) chk("timeout_busy", o_busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel = 1'b0; rst = 1'b1; miss_detected = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_addr = '0; mem_ready = 1'b0; memory_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk_quiet("por", 16'h0);

    run_miss(16'h1234, 1'b0, 16'h0000, 1, 2, -1, -1);  // clean miss
    run_miss(16'h1234, 1'b1, 16'h5678, 1, 2, -1, -1);  // dirty victim
    run_miss(16'h1234, 1'b1, 16'h5678, 2, 2, -1, -1);  // stalled handshakes
    run_miss(16'h1234, 1'b0, 16'h0000, 1, 2, 3, -1);   // stray miss during fill
    run_miss(16'h1234, 1'b0, 16'h0000, 1, 2, -1, 3);   // reset after 3 beats
    run_miss(16'h1234, 1'b0, 16'h0000, 1, 2, -1, -1);  // restart from offset 0
    run_miss(16'hFFF7, 1'b1, 16'hFFFF, 0, 1, -1, -1);  // top of address space
    for (int i = 0; i < 10; i++)
      run_miss(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 0,
               $urandom_range(1, 4), -1, -1);

    sel = 1'b1;
    pulse_reset();
    run_miss(16'h1234, 1'b0, 16'h0000, 1, 2, -1, -1);
    run_miss(16'h1234, 1'b1, 16'h5678, 2, 3, -1, -1);
    for (int i = 0; i < 4; i++)
      run_miss(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 0,
               $urandom_range(1, 3), -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
